mlp_layer_sequencer: RTL and testbench

//   Upstream driver for one cordic_neuron instance that computes a full MLP layer one neuron at a time.
//   - Accepts an input vector of NUM_INPUTS samples from a valid/ready stream.
//   - For each neuron, fetches that neuron's weights and bias from synchronous memories.
//   - Packs the operands into the neuron's flattened ports, pulses start and waits for output_valid.
//   - Emits each activation on a valid/ready output stream tagged with the neuron index.

---
 rtl/mlp_pkg.sv | 25 ++
 rtl/mlp_layer_sequencer_if.sv | 29 ++
 rtl/mlp_operand_pack.sv | 40 ++++
 rtl/mlp_layer_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// Shared constants, FSM encoding and index-width helper for the MLP layer sequencer.
package mlp_pkg;

  localparam int DEF_INPUT_WIDTH  = 20;
  localparam int DEF_ACCUM_WIDTH  = 48;
  localparam int DEF_OUTPUT_WIDTH = 20;
  localparam int DEF_NUM_INPUTS   = 4;
  localparam int DEF_NUM_NEURONS  = 8;
  localparam int DEF_WADDR_W      = 8;
  localparam int DEF_TIMEOUT_CYC  = 1023;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD_IN  = 3'd1;
  localparam logic [2:0] ST_FETCH_W  = 3'd2;
  localparam logic [2:0] ST_START    = 3'd3;
  localparam logic [2:0] ST_WAIT_NEU = 3'd4;
  localparam logic [2:0] ST_EMIT     = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  // Bits needed to index 'depth' items; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mlp_layer_sequencer_if.sv
// Input sample stream and indexed activation stream of the layer sequencer.
interface mlp_layer_sequencer_if
  import mlp_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int IDX_W        = idx_width(DEF_NUM_NEURONS)
) ();

  logic                    in_valid;
  logic [INPUT_WIDTH-1:0]  in_data;
  logic                    in_ready;

  logic                    out_valid;
  logic [OUTPUT_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]        out_index;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index
  );

endinterface

// File: rtl/mlp_operand_pack.sv
// DEPTH x WIDTH operand register with an indexed write port and a flattened read port.
module mlp_operand_pack #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4,
  parameter int IDX_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH*DEPTH-1:0] flat
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_elem
      logic [WIDTH-1:0] elem_q;
      logic [WIDTH-1:0] elem_d;

      always_comb begin
        elem_d = elem_q;
        if (wr_en && (wr_idx == IDX_W'(gi))) begin
          elem_d = wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          elem_q <= '0;
        end else begin
          elem_q <= elem_d;
        end
      end

      assign flat[gi*WIDTH +: WIDTH] = elem_q;
    end
  endgenerate

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Drives one neuron through a full MLP layer: load inputs, fetch weights/bias per neuron,
// start the neuron, wait for its result (with timeout) and emit it tagged with the neuron index.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int NUM_INPUTS   = DEF_NUM_INPUTS,
  parameter int NUM_NEURONS  = DEF_NUM_NEURONS,
  parameter int WADDR_W      = DEF_WADDR_W,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  localparam int NIDX_W      = idx_width(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              layer_start,
  mlp_layer_sequencer_if.slave              stream,
  output logic                              wmem_rd_en,
  output logic [WADDR_W-1:0]                wmem_addr,
  input  logic [INPUT_WIDTH-1:0]            wmem_rdata,
  output logic [NIDX_W-1:0]                 bmem_addr,
  input  logic [ACCUM_WIDTH-1:0]            bmem_rdata,
  output logic                              neu_start,
  output logic [INPUT_WIDTH*NUM_INPUTS-1:0] neu_inputs_flat,
  output logic [INPUT_WIDTH*NUM_INPUTS-1:0] neu_weights_flat,
  output logic [ACCUM_WIDTH-1:0]            neu_bias,
  input  logic [OUTPUT_WIDTH-1:0]           neu_output_data,
  input  logic                              neu_output_valid,
  output logic                              layer_done,
  output logic                              busy,
  output logic                              err_timeout
);

  // k spans 0..NUM_INPUTS so it can also sequence the trailing fetch capture cycle.
  localparam int KW = idx_width(NUM_INPUTS + 1);
  localparam int TW = idx_width(TIMEOUT_CYC + 1);

  logic [2:0]              state_q,    state_d;
  logic [KW-1:0]           k_q,        k_d;
  logic [NIDX_W-1:0]       n_q,        n_d;
  logic [TW-1:0]           tmo_q,      tmo_d;
  logic [ACCUM_WIDTH-1:0]  bias_q,     bias_d;
  logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                    err_q,      err_d;

  logic          in_wr;
  logic          w_wr;
  logic [KW-1:0] w_idx;

  assign w_idx = k_q - KW'(1);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    tmo_d      = tmo_q;
    bias_d     = bias_q;
    out_data_d = out_data_q;
    err_d      = err_q;
    in_wr      = 1'b0;
    w_wr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (layer_start) begin
          state_d = ST_LOAD_IN;
          k_d     = '0;
          n_d     = '0;
          err_d   = 1'b0;
        end
      end

      ST_LOAD_IN: begin
        if (stream.in_valid) begin
          in_wr = 1'b1;
          if (k_q == KW'(NUM_INPUTS - 1)) begin
            k_d     = '0;
            state_d = ST_FETCH_W;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      // Cycle k strobes weight k; the data returning in cycle k belongs to weight k-1.
      ST_FETCH_W: begin
        if (k_q != '0) begin
          w_wr = 1'b1;
        end
        if (k_q == KW'(1)) begin
          bias_d = bmem_rdata;
        end
        if (k_q == KW'(NUM_INPUTS)) begin
          k_d     = '0;
          state_d = ST_START;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      ST_START: begin
        tmo_d   = '0;
        state_d = ST_WAIT_NEU;
      end

      // A result arriving on the last allowed cycle takes priority over the timeout.
      ST_WAIT_NEU: begin
        if (neu_output_valid) begin
          out_data_d = neu_output_data;
          state_d    = ST_EMIT;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d      = 1'b1;
          out_data_d = '0;
          state_d    = ST_EMIT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_EMIT: begin
        if (stream.out_ready) begin
          if (n_q == NIDX_W'(NUM_NEURONS - 1)) begin
            state_d = ST_DONE;
          end else begin
            n_d     = n_q + NIDX_W'(1);
            k_d     = '0;
            state_d = ST_FETCH_W;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      n_q        <= '0;
      tmo_q      <= '0;
      bias_q     <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      n_q        <= n_d;
      tmo_q      <= tmo_d;
      bias_q     <= bias_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
    end
  end

  mlp_operand_pack #(
    .WIDTH (INPUT_WIDTH),
    .DEPTH (NUM_INPUTS),
    .IDX_W (KW)
  ) u_inputs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_wr),
    .wr_idx  (k_q),
    .wr_data (stream.in_data),
    .flat    (neu_inputs_flat)
  );

  mlp_operand_pack #(
    .WIDTH (INPUT_WIDTH),
    .DEPTH (NUM_INPUTS),
    .IDX_W (KW)
  ) u_weights (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr),
    .wr_idx  (w_idx),
    .wr_data (wmem_rdata),
    .flat    (neu_weights_flat)
  );

  assign wmem_rd_en = (state_q == ST_FETCH_W) && (k_q < KW'(NUM_INPUTS));
  assign wmem_addr  = wmem_rd_en
                    ? (WADDR_W'(n_q) * WADDR_W'(NUM_INPUTS) + WADDR_W'(k_q))
                    : '0;
  assign bmem_addr  = n_q;

  assign neu_start        = (state_q == ST_START);
  assign neu_bias         = bias_q;
  assign stream.in_ready  = (state_q == ST_LOAD_IN);
  assign stream.out_valid = (state_q == ST_EMIT);
  assign stream.out_data  = out_data_q;
  assign stream.out_index = n_q;
  assign layer_done       = (state_q == ST_DONE);
  assign busy             = (state_q != ST_IDLE);
  assign err_timeout      = err_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed + randomized bench for mlp_layer_sequencer with memory and neuron reference models.
module tb_mlp_layer_sequencer;
  import mlp_pkg::*;

  localparam int IW = 20;
  localparam int AW = 48;
  localparam int OW = 20;
  localparam int NI = 4;
  localparam int NN = 8;
  localparam int WA = 8;
  localparam int TO = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic layer_start = 1'b0;
  logic wmem_rd_en;
  logic [WA-1:0] wmem_addr;
  logic [IW-1:0] wmem_rdata = '0;
  logic [2:0] bmem_addr;
  logic [AW-1:0] bmem_rdata = '0;
  logic neu_start;
  logic [IW*NI-1:0] neu_inputs_flat;
  logic [IW*NI-1:0] neu_weights_flat;
  logic [AW-1:0] neu_bias;
  logic [OW-1:0] neu_output_data;
  logic neu_output_valid;
  logic layer_done;
  logic busy;
  logic err_timeout;

  mlp_layer_sequencer_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .IDX_W(3)) sif ();

  mlp_layer_sequencer #(
    .INPUT_WIDTH(IW), .ACCUM_WIDTH(AW), .OUTPUT_WIDTH(OW), .NUM_INPUTS(NI),
    .NUM_NEURONS(NN), .WADDR_W(WA), .TIMEOUT_CYC(TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .layer_start      (layer_start),
    .stream           (sif),
    .wmem_rd_en       (wmem_rd_en),
    .wmem_addr        (wmem_addr),
    .wmem_rdata       (wmem_rdata),
    .bmem_addr        (bmem_addr),
    .bmem_rdata       (bmem_rdata),
    .neu_start        (neu_start),
    .neu_inputs_flat  (neu_inputs_flat),
    .neu_weights_flat (neu_weights_flat),
    .neu_bias         (neu_bias),
    .neu_output_data  (neu_output_data),
    .neu_output_valid (neu_output_valid),
    .layer_done       (layer_done),
    .busy             (busy),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  // Reference world: stimulus vectors, memories, neuron responses.
  logic [IW-1:0] in_vec [NI];
  logic [IW-1:0] wmem [256];
  logic [AW-1:0] bmem [NN];
  logic [OW-1:0] resp [NN];
  int hang_n = -1;
  int lat = 7;
  int layer_base = 0;
  logic spur_valid = 1'b0;

  // Written only by the neuron model process.
  int cyc = 0;
  int total_starts = 0;
  int pend = 0;
  int pn;
  logic mdl_valid = 1'b0;
  logic [OW-1:0] mdl_data = '0;
  logic [IW*NI-1:0] obs_in [NN];
  logic [IW*NI-1:0] obs_w [NN];
  logic [AW-1:0] obs_b [NN];
  int start_cyc [NN];

  int checks = 0;
  int errors = 0;

  assign neu_output_valid = mdl_valid | spur_valid;
  assign neu_output_data  = mdl_valid ? mdl_data : 20'hBAD55;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wmem_rd_en) wmem_rdata <= wmem[wmem_addr];
    bmem_rdata <= bmem[bmem_addr];
  end

  // Neuron model: records operands at each start, answers resp[n] after 'lat' cycles.
  always begin
    @(posedge clk);
    #2;
    mdl_valid = 1'b0;
    if (rst) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          mdl_valid = 1'b1;
          mdl_data  = resp[pn];
        end
      end
      if (neu_start) begin
        pn = (total_starts - layer_base) & (NN - 1);
        obs_in[pn]    = neu_inputs_flat;
        obs_w[pn]     = neu_weights_flat;
        obs_b[pn]     = neu_bias;
        start_cyc[pn] = cyc;
        total_starts  = total_starts + 1;
        if (pn != hang_n) pend = lat;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [IW*NI-1:0] exp_inputs();
    logic [IW*NI-1:0] v;
    for (int k = 0; k < NI; k++) v[k*IW +: IW] = in_vec[k];
    return v;
  endfunction

  function automatic logic [IW*NI-1:0] exp_weights(input int n);
    logic [IW*NI-1:0] v;
    for (int k = 0; k < NI; k++) v[k*IW +: IW] = wmem[n*NI + k];
    return v;
  endfunction

  task automatic check_zero(input string t);
    chk({t, "_out_valid"}, sif.out_valid, 0);
    chk({t, "_out_data"}, sif.out_data, 0);
    chk({t, "_out_index"}, sif.out_index, 0);
    chk({t, "_in_ready"}, sif.in_ready, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_err"}, err_timeout, 0);
    chk({t, "_done"}, layer_done, 0);
    chk({t, "_start"}, neu_start, 0);
    chk({t, "_rd_en"}, wmem_rd_en, 0);
    chk({t, "_waddr"}, wmem_addr, 0);
    chk({t, "_baddr"}, bmem_addr, 0);
    chk({t, "_in_flat"}, neu_inputs_flat, 0);
    chk({t, "_w_flat"}, neu_weights_flat, 0);
    chk({t, "_bias"}, neu_bias, 0);
  endtask

  task automatic randomize_layer();
    for (int i = 0; i < NI; i++) in_vec[i] = IW'($urandom);
    for (int a = 0; a < NN*NI; a++) wmem[a] = IW'($urandom);
    for (int n = 0; n < NN; n++) begin
      bmem[n] = AW'({$urandom, $urandom});
      resp[n] = OW'($urandom);
    end
    lat = $urandom_range(1, 12);
  endtask

  task automatic run_layer(input int gap, input int stall, input int hang,
                           input bit disturb, input int rst_n);
    logic got;
    int seen;
    logic [OW-1:0] exp_d;
    hang_n = hang;
    layer_base = total_starts;
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err_timeout, 0);
    for (int i = 0; i < NI; i++) begin
      if (gap != 0) begin
        sif.in_valid = 1'b0;
        sif.in_data  = IW'($urandom);
        tick();
      end
      if (disturb && i == 2) begin
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
      end
      sif.in_valid = 1'b1;
      sif.in_data  = in_vec[i];
      got = 1'b0;
      for (int w = 0; w < 50 && !got; w++) begin
        got = sif.in_ready;
        tick();
      end
      chk("in_accept", got, 1);
    end
    sif.in_valid = 1'b0;
    chk("in_ready_after_load", sif.in_ready, 0);

    for (int n = 0; n < NN; n++) begin
      if (n == rst_n) begin
        got = 1'b0;
        for (int w = 0; w < 100 && !got; w++) begin
          got = (total_starts - layer_base) == n + 1;
          tick();
        end
        chk("wait_start_before_rst", got, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("midrst");
        hang_n = -1;
        return;
      end
      got = 1'b0;
      for (int w = 0; w < TO + 200 && !got; w++) begin
        got = sif.out_valid;
        if (!got) tick();
      end
      chk("out_valid_wait", got, 1);
      if (!got) return;
      seen  = cyc;
      exp_d = (n == hang) ? '0 : resp[n];
      chk("out_data", sif.out_data, exp_d);
      chk("out_index", sif.out_index, n);
      chk("layer_done_early", layer_done, 0);
      chk("err_timeout", err_timeout, (hang >= 0 && n >= hang));
      chk("op_inputs", obs_in[n], exp_inputs());
      chk("op_weights", obs_w[n], exp_weights(n));
      chk("op_bias", obs_b[n], bmem[n]);
      if (n == hang) chk("tmo_latency", seen - start_cyc[n], TO + 1);
      for (int s = 0; s < stall; s++) begin
        if (disturb && s == 0) layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        chk("stall_valid", sif.out_valid, 1);
        chk("stall_data", sif.out_data, exp_d);
        chk("stall_index", sif.out_index, n);
      end
      sif.out_ready = 1'b1;
      tick();
      sif.out_ready = 1'b0;
      chk("layer_done", layer_done, n == NN - 1);
      chk("out_valid_drop", sif.out_valid, 0);
      if (disturb && n < NN - 1) begin
        spur_valid = 1'b1;
        tick();
        spur_valid = 1'b0;
      end
    end
    tick();
    chk("layer_done_pulse", layer_done, 0);
    chk("idle_after_done", busy, 0);
    chk("start_count", total_starts - layer_base, NN);
    hang_n = -1;
  endtask

  initial begin
    logic [IW*NI-1:0] lit;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_no_start", busy, 0);

    // Deterministic layer: inputs 1..4, weight[a]=a+1, bias[n]=16n, result 100+n after 7 cycles.
    for (int i = 0; i < NI; i++) in_vec[i] = IW'(i + 1);
    for (int a = 0; a < NN*NI; a++) wmem[a] = IW'(a + 1);
    for (int n = 0; n < NN; n++) begin
      bmem[n] = AW'(n * 16);
      resp[n] = OW'(100 + n);
    end
    lat = 7;
    run_layer(0, 0, -1, 1'b0, -1);
    lit = {20'd4, 20'd3, 20'd2, 20'd1};
    chk("n0_inputs_lit", obs_in[0], lit);
    chk("n0_weights_lit", obs_w[0], lit);
    chk("n0_bias_lit", obs_b[0], 0);
    lit = {20'd8, 20'd7, 20'd6, 20'd5};
    chk("n1_weights_lit", obs_w[1], lit);
    chk("n1_bias_lit", obs_b[1], 16);

    randomize_layer();
    run_layer(1, 5, -1, 1'b0, -1);

    randomize_layer();
    run_layer(0, 0, 3, 1'b0, -1);
    chk("err_sticky_idle", err_timeout, 1);

    randomize_layer();
    run_layer(1, 2, -1, 1'b1, -1);

    randomize_layer();
    lat = 7;
    run_layer(0, 0, -1, 1'b0, 2);

    randomize_layer();
    run_layer(0, 1, -1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
